// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_seq_state_t;

    // Width of the failed-attempt counter; it saturates at its all-ones value.
    localparam int unsigned RETRY_W = 4;

    // Largest of three values, used to size the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// Multi-flop synchronizer for a single asynchronous level, with synchronous reset to 0.
module pll_seq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock qualification sequencer with lock-loss detection and bounded retries.
// Outputs are registered from the current state, so they follow the state one cycle later;
// lock_lost is registered from the RUN exit decision and so marks the transition cycle itself.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE    = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 1048576,
    parameter int unsigned MAX_RETRY    = 7,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pll_locked,
    input  logic               i_relock_req,
    output logic               o_pll_rst,
    output logic               o_rst_out,
    output logic               o_ready,
    output logic               o_fail,
    output logic               o_lock_lost,
    output logic [RETRY_W-1:0] o_retry_cnt
);

    localparam int unsigned CNT_W = $clog2(max3(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT)) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    // A limit above the saturating counter's range can never be reached: retry forever.
    localparam bit                 RETRY_BOUNDED = (MAX_RETRY != 0) &&
                                                   (MAX_RETRY < (1 << RETRY_W));
    localparam logic [RETRY_W-1:0] RETRY_LIMIT   = RETRY_W'(MAX_RETRY);

    pll_seq_state_t     r_state;
    pll_seq_state_t     w_state_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [RETRY_W-1:0] w_retry_d;
    logic [RETRY_W-1:0] w_retry_inc;
    logic               w_locked_s;

    logic r_pll_rst;
    logic r_rst_out;
    logic r_ready;
    logic r_fail;
    logic r_lock_lost;

    pll_seq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_d  (i_pll_locked),
        .o_q  (w_locked_s)
    );

    assign w_retry_inc = (r_retry_cnt == '1) ? r_retry_cnt : r_retry_cnt + RETRY_W'(1);

    // Next-state and retry-count decisions.
    always_comb begin
        w_state_d = r_state;
        w_retry_d = r_retry_cnt;
        unique case (r_state)
            RESET_PLL: begin
                // relock_req is ignored here: the PLL is already being reset.
                if (r_cnt == RST_LAST) begin
                    w_state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Priority: relock, then lock, then timeout.
                if (i_relock_req) begin
                    w_state_d = RESET_PLL;
                end else if (w_locked_s) begin
                    w_state_d = STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_retry_d = w_retry_inc;
                    if (RETRY_BOUNDED && (w_retry_inc == RETRY_LIMIT)) begin
                        w_state_d = FAIL;
                    end else begin
                        w_state_d = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                // A glitch restarts qualification without costing a retry.
                if (i_relock_req) begin
                    w_state_d = RESET_PLL;
                end else if (!w_locked_s) begin
                    w_state_d = WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_d = RUN;
                    w_retry_d = '0;
                end
            end
            RUN: begin
                if (i_relock_req || !w_locked_s) begin
                    w_state_d = RESET_PLL;
                end
            end
            FAIL: begin
                if (i_relock_req) begin
                    w_state_d = RESET_PLL;
                    w_retry_d = '0;
                end
            end
            default: begin
                w_state_d = RESET_PLL;
            end
        endcase
    end

    // State, retry count and the shared phase counter (cleared on every state change).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RESET_PLL;
            r_retry_cnt <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_retry_cnt <= w_retry_d;
            if (w_state_d != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == RESET_PLL) || (r_state == WAIT_LOCK) ||
                         (r_state == STABLE)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Registered outputs decoded from the state held this cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pll_rst   <= 1'b1;
            r_rst_out   <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_pll_rst   <= (r_state == RESET_PLL) || (r_state == FAIL);
            r_rst_out   <= (r_state != RUN);
            r_ready     <= (r_state == RUN);
            r_fail      <= (r_state == FAIL);
            // Pulses on a lock drop in RUN even when relock_req arrives in the same cycle.
            r_lock_lost <= (r_state == RUN) && !w_locked_s;
        end
    end

    assign o_pll_rst   = r_pll_rst;
    assign o_rst_out   = r_rst_out;
    assign o_ready     = r_ready;
    assign o_fail      = r_fail;
    assign o_lock_lost = r_lock_lost;
    assign o_retry_cnt = r_retry_cnt;

endmodule
